// File: rtl/spi_pkg.sv
// Shared state encoding and default sizing for the SPI arbiter slice.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    BUSY,
    GAP
  } arb_state_t;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_MESSAGE_WIDTH = 8;
  localparam int DEF_GAP_CYCLES    = 2;

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// Round-robin winner selection: first asserted request after i_last, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the winner is accepted.
module rr_picker
  import spi_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic         o_any,
  output logic [W-1:0] o_winner
);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;

  // Index of the requester sitting 'off' slots after 'last', modulo N.
  function automatic logic [W-1:0] rot_idx(input logic [W-1:0] last, input logic [W-1:0] off);
    int s;
    s = int'(last) + 1 + int'(off);
    if (s >= N) s = s - N;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

  // Rotate the request vector so the slot just after the last grant lands at bit 0.
  always_comb begin
    w_rot = '0;
    for (int p = 0; p < N; p++) begin
      w_rot[p] = i_req[rot_idx(i_last, W'(p))];
    end
  end

  // Lowest set rotated bit wins; map its offset back to a requester index.
  always_comb begin
    o_any = |i_req;
    w_off = '0;
    for (int p = N - 1; p >= 0; p--) begin
      if (w_rot[p]) w_off = W'(p);
    end
    o_winner = rot_idx(i_last, w_off);
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_gen transmitter among NUM_REQ requesters with round-robin grants.
// Latency: accept at edge 0, trigger high in cycle 1, spi_gen select low from cycle 2.
// Backpressure: ready is offered to one requester only while idle; others hold valid.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int MESSAGE_WIDTH = DEF_MESSAGE_WIDTH,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_REQ-1:0]               req_valid_in,
  input  logic [NUM_REQ*MESSAGE_WIDTH-1:0] req_msg_in,
  output logic [NUM_REQ-1:0]               req_ready_out,
  output logic [NUM_REQ-1:0]               done_out,
  output logic [MESSAGE_WIDTH-1:0]         gen_msg_out,
  output logic                             gen_trigger_out,
  input  logic                             gen_sel_in,
  output logic [NUM_REQ-1:0]               sel_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  arb_state_t               r_state;
  logic [IW-1:0]            r_grant;
  logic [IW-1:0]            r_last;
  logic [GW-1:0]            r_gap;
  logic [MESSAGE_WIDTH-1:0] r_msg;
  logic                     r_trig;
  logic [NUM_REQ-1:0]       r_done;

  logic                     w_any;
  logic [IW-1:0]            w_winner;
  logic [NUM_REQ-1:0]       w_win_oh;
  logic [NUM_REQ-1:0]       w_grant_oh;
  logic                     w_accept;

  rr_picker #(
    .N (NUM_REQ),
    .W (IW)
  ) u_picker (
    .i_req    (req_valid_in),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // One-hot views of the current winner and of the granted requester.
  always_comb begin
    w_win_oh   = '0;
    w_grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_oh[i]   = (w_winner == IW'(i));
      w_grant_oh[i] = (r_grant == IW'(i));
    end
  end

  // Ready goes only to the winner and only while idle; the winner is always valid.
  always_comb begin
    w_accept      = (r_state == IDLE) && w_any;
    req_ready_out = w_accept ? w_win_oh : '0;
  end

  // Steer spi_gen's shared select onto the granted device while its frame is live.
  always_comb begin
    sel_out = '1;
    if (r_state == WAIT_START || r_state == BUSY) begin
      sel_out = ~(w_grant_oh & {NUM_REQ{~gen_sel_in}});
    end
  end

  // Transaction sequencing: accept, launch, follow spi_gen's select, then enforce the gap.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_gap   <= '0;
      r_msg   <= '0;
      r_trig  <= 1'b0;
      r_done  <= '0;
    end else begin
      r_trig <= 1'b0;
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_msg   <= req_msg_in[w_winner*MESSAGE_WIDTH +: MESSAGE_WIDTH];
            r_grant <= w_winner;
            r_last  <= w_winner;
            r_trig  <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_state <= WAIT_START;
        end
        WAIT_START: begin
          if (!gen_sel_in) r_state <= BUSY;
        end
        BUSY: begin
          if (gen_sel_in) begin
            r_done <= w_grant_oh;
            r_gap  <= GW'(GAP_CYCLES);
            if (GAP_CYCLES == 0) r_state <= IDLE;
            else                 r_state <= GAP;
          end
        end
        GAP: begin
          if (r_gap <= GW'(1)) r_state <= IDLE;
          else                 r_gap   <= r_gap - GW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gen_msg_out     = r_msg;
  assign gen_trigger_out = r_trig;
  assign done_out        = r_done;

endmodule
